// File: rtl/tdm_demux_four.sv
// -----------------------------------------------------------------------------
// tdm_demux_four
//
// Purpose:
//   Splits a serial time-division word stream into four channel holding
//   registers. A start-of-frame marker aligns the stream to slot 0. Each
//   completed four-word frame is also copied into an aligned frame shadow
//   register.
//
// Configuration macro:
//   TDM_DEMUX_STRICT_SOF_EN
//     defined   : in LOCK, a word at slot 0 without in_sof is an alignment
//                 error. The block pulses sync_err, drops the word and returns
//                 to HUNT.
//     undefined : that word is taken as slot 0 (free-running framing).
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   in_data/in_sof carry a word this cycle
//   in_data      in   WIDTH-bit serial word
//   in_sof       in   start of frame (word is slot 0); ignored when !in_valid
//   ch_data      out  4 x WIDTH channel holding registers, channel k at [k*WIDTH +: WIDTH]
//   ch_valid     out  one-cycle strobe per channel update (one-hot or zero)
//   frame_data   out  4 x WIDTH aligned frame shadow, same layout as ch_data
//   frame_valid  out  one-cycle strobe, frame_data was updated
//   locked       out  high while in LOCK (this is the FSM state)
//   sync_err     out  one-cycle strobe on a frame alignment violation
//
// Handshake: valid-only input, with no backpressure. A word is consumed on
// every rising edge where in_valid=1. All outputs are registered and appear
// one cycle after the accepting edge.
// -----------------------------------------------------------------------------
module tdm_demux_four #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sof,
    output logic [4*WIDTH-1:0]   ch_data,
    output logic [3:0]           ch_valid,
    output logic [4*WIDTH-1:0]   frame_data,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 sync_err
);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           slot_q, slot_d;
    logic [4*WIDTH-1:0]   ch_data_q, ch_data_d;
    logic [4*WIDTH-1:0]   frame_data_q, frame_data_d;
    logic [3:0]           ch_valid_q, ch_valid_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 sync_err_q, sync_err_d;

    // Decoded per-word decision: whether the word is stored, and which slot
    // receives it.
    logic                 accept;
    logic [1:0]           wr_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            slot_q        <= 2'd0;
            ch_data_q     <= '0;
            frame_data_q  <= '0;
            ch_valid_q    <= 4'd0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            ch_data_q     <= ch_data_d;
            frame_data_q  <= frame_data_d;
            ch_valid_q    <= ch_valid_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        ch_data_d     = ch_data_q;
        frame_data_d  = frame_data_q;
        ch_valid_d    = 4'd0;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        accept        = 1'b0;
        wr_slot       = slot_q;

        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // Only an sof word can establish alignment. Other words are dropped.
                    if (in_sof) begin
                        accept  = 1'b1;
                        wr_slot = 2'd0;
                        state_d = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (in_sof) begin
                        // sof away from slot 0 is a resync. The partial frame is
                        // abandoned, and because wr_slot is 0 no frame strobe
                        // can fire for it.
                        accept     = 1'b1;
                        wr_slot    = 2'd0;
                        sync_err_d = (slot_q != 2'd0);
                    end else if (slot_q == 2'd0) begin
`ifdef TDM_DEMUX_STRICT_SOF_EN
                        sync_err_d = 1'b1;
                        state_d    = ST_HUNT;
                        slot_d     = 2'd0;
`else
                        accept     = 1'b1;
                        wr_slot    = 2'd0;
`endif
                    end else begin
                        accept  = 1'b1;
                        wr_slot = slot_q;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (accept) begin
            slot_d = wr_slot + 2'd1;
            ch_data_d[wr_slot*WIDTH +: WIDTH] = in_data;
            ch_valid_d[wr_slot] = 1'b1;
            // Slots 0-2 of this frame are already in ch_data_q: each one was
            // written at least one edge before slot 3 can be accepted.
            if (wr_slot == 2'd3) begin
                frame_valid_d = 1'b1;
                frame_data_d  = {in_data, ch_data_q[3*WIDTH-1:0]};
            end
        end
    end

    assign ch_data     = ch_data_q;
    assign ch_valid    = ch_valid_q;
    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == ST_LOCK);

endmodule
